// File: rtl/hour_tick_timebase_if.sv
// hour_tick_timebase_if: control inputs and time/status outputs of the seconds/minutes timebase
//   en         run enable (freezes prescaler and counters in RUN when low)
//   mode_btn   synchronised single-cycle pulse, advances the set-mode FSM
//   inc_btn    synchronised single-cycle pulse, increments the field being set
//   seconds    current seconds 0-59
//   minutes    current minutes 0-59
//   sec_tick   one-cycle pulse per seconds advance in RUN
//   hour_tick  one-cycle pulse on 59:59 -> 00:00, count-enable for the hour counter
//   set_state  00 RUN, 01 SET_MIN, 10 SET_SEC
//   blink      display blink gate for the field being set
interface hour_tick_timebase_if;
   logic       en;
   logic       mode_btn;
   logic       inc_btn;
   logic [5:0] seconds;
   logic [5:0] minutes;
   logic       sec_tick;
   logic       hour_tick;
   logic [1:0] set_state;
   logic       blink;
   modport master (output en, mode_btn, inc_btn,
                   input seconds, minutes, sec_tick, hour_tick, set_state, blink);
   modport slave  (input en, mode_btn, inc_btn,
                   output seconds, minutes, sec_tick, hour_tick, set_state, blink);
endinterface

// File: rtl/hour_tick_timebase.sv
// hour_tick_timebase: 1 Hz prescaler, mm:ss counter with hour_tick pulse and a minute/second set-mode FSM
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      hour_tick_timebase_if.slave (en, mode_btn, inc_btn in; time, pulses, set_state, blink out)
//   DIV      clk cycles per second tick
//   FAST_DIV divisor used instead of DIV when TIMEBASE_FAST_EN is defined
module hour_tick_timebase #(
   parameter int DIV      = 50000000,
   parameter int FAST_DIV = 4
) (
   input logic                  clk,
   input logic                  reset_n,
   hour_tick_timebase_if.slave  bus
);
`ifdef TIMEBASE_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   localparam int D = FAST ? FAST_DIV : DIV;
   localparam int W = $clog2(D);
   typedef enum logic [1:0] {RUN = 2'b00, SET_MIN = 2'b01, SET_SEC = 2'b10} state_t;
   state_t       state, state_nxt;
   logic [W-1:0] pre, pre_nxt;
   logic [5:0]   sec, sec_nxt, min, min_nxt;
   logic         st, st_nxt, ht, ht_nxt, blink, blink_nxt;
   logic         term;
   logic [5:0]   sec_inc, min_inc;
   assign term    = pre == W'(D - 1);
   assign sec_inc = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
   assign min_inc = (min == 6'd59) ? 6'd0 : min + 6'd1;
   always_comb begin
      state_nxt = state;
      pre_nxt   = pre;
      sec_nxt   = sec;
      min_nxt   = min;
      st_nxt    = 1'b0;
      ht_nxt    = 1'b0;
      if (state == RUN) begin
         // mode_btn takes priority over a coincident terminal count
         if (bus.mode_btn) begin
            state_nxt = SET_MIN;
            pre_nxt   = '0;
         end else if (bus.en) begin
            pre_nxt = term ? '0 : pre + 1'b1;
            if (term) begin
               st_nxt  = 1'b1;
               sec_nxt = sec_inc;
               min_nxt = (sec == 6'd59) ? min_inc : min;
               ht_nxt  = (sec == 6'd59) && (min == 6'd59);
            end
         end
      end else begin
         // prescaler free-runs in set states so blink keeps its cadence
         pre_nxt = term ? '0 : pre + 1'b1;
         if (bus.mode_btn) begin
            state_nxt = (state == SET_MIN) ? SET_SEC : RUN;
            if (state != SET_MIN) pre_nxt = '0;
         end else if (bus.inc_btn) begin
            min_nxt = (state == SET_MIN) ? min_inc : min;
            sec_nxt = (state == SET_MIN) ? sec : sec_inc;
         end
      end
      // registered blink tracks the prescaler value it will sit beside
      blink_nxt = (state_nxt != RUN) && (pre_nxt < W'(D / 2));
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RUN;
         pre   <= '0;
         sec   <= '0;
         min   <= '0;
         st    <= 1'b0;
         ht    <= 1'b0;
         blink <= 1'b0;
      end else begin
         state <= state_nxt;
         pre   <= pre_nxt;
         sec   <= sec_nxt;
         min   <= min_nxt;
         st    <= st_nxt;
         ht    <= ht_nxt;
         blink <= blink_nxt;
      end
   end
   assign bus.seconds   = sec;
   assign bus.minutes   = min;
   assign bus.sec_tick  = st;
   assign bus.hour_tick = ht;
   assign bus.set_state = state;
   assign bus.blink     = blink;
endmodule

// File: tb/tb_hour_tick_timebase.sv
// tb_hour_tick_timebase: directed plus randomized check of hour_tick_timebase against a time-of-hour model
module tb_hour_tick_timebase;
   localparam int D = 4;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   hour_tick_timebase_if bus();
   hour_tick_timebase #(.DIV(D), .FAST_DIV(D)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;
   int vectors = 0;
   int miscompares = 0;
   // model: mode 0 RUN / 1 SET_MIN / 2 SET_SEC, prescale count, seconds into the hour
   int mst = 0, pre = 0, t = 0;
   bit st_e = 0, ht_e = 0;
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic check_all();
      chk("seconds", 32'(bus.seconds), t % 60);
      chk("minutes", 32'(bus.minutes), t / 60);
      chk("sec_tick", 32'(bus.sec_tick), 32'(st_e));
      chk("hour_tick", 32'(bus.hour_tick), 32'(ht_e));
      chk("set_state", 32'(bus.set_state), mst);
      chk("blink", 32'(bus.blink), (mst != 0 && pre < D / 2) ? 1 : 0);
   endtask
   task automatic model_reset();
      mst = 0; pre = 0; t = 0; st_e = 0; ht_e = 0;
   endtask
   task automatic model_clk(bit e, bit m, bit i);
      st_e = 0; ht_e = 0;
      if (mst == 0) begin
         if (m) begin
            mst = 1; pre = 0;
         end else if (e) begin
            if (pre == D - 1) begin
               pre = 0; t = (t + 1) % 3600; st_e = 1; ht_e = (t == 0);
            end else pre++;
         end
      end else if (mst == 2 && m) begin
         mst = 0; pre = 0;
      end else begin
         pre = (pre + 1) % D;
         if (m) mst = 2;
         else if (i && mst == 1) t = ((t / 60 + 1) % 60) * 60 + t % 60;
         else if (i) t = (t / 60) * 60 + (t % 60 + 1) % 60;
      end
   endtask
   task automatic cyc(bit e, bit m, bit i);
      bus.en = e; bus.mode_btn = m; bus.inc_btn = i;
      @(posedge clk);
      model_clk(e, m, i);
      #1;
      check_all();
   endtask
   // enters set mode from RUN and dials in mm:ss; optionally stays in SET_SEC
   task automatic set_time(int tm, int ts, bit stay);
      cyc(0, 1, 0);
      for (int k = (tm - t / 60 + 60) % 60; k > 0; k--) cyc(0, 0, 1);
      cyc(0, 1, 0);
      for (int k = (ts - t % 60 + 60) % 60; k > 0; k--) cyc(0, 0, 1);
      if (!stay) cyc(0, 1, 0);
   endtask
   initial begin
      bus.en = 0; bus.mode_btn = 0; bus.inc_btn = 0;
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      reset_n = 1'b1;
      // free run: ticks on cycles 4, 8, 12
      for (int k = 1; k <= 12; k++) begin
         cyc(1, 0, 0);
         chk("tick_cycle", 32'(bus.sec_tick), (k % 4 == 0) ? 1 : 0);
      end
      chk("run12_sec", 32'(bus.seconds), 3);
      // preload 59:58 and roll over the hour
      set_time(59, 58, 0);
      repeat (8) cyc(1, 0, 0);
      chk("roll_hour_tick", 32'(bus.hour_tick), 1);
      chk("roll_sec_tick", 32'(bus.sec_tick), 1);
      chk("roll_min", 32'(bus.minutes), 0);
      cyc(1, 0, 0);
      chk("hour_tick_drop", 32'(bus.hour_tick), 0);
      // 12:30, advance prescaler to 2, hold with en=0, then resume
      set_time(12, 30, 0);
      repeat (2) cyc(1, 0, 0);
      repeat (20) cyc(0, 0, 0);
      chk("hold_min", 32'(bus.minutes), 12);
      cyc(1, 0, 0);
      chk("resume_no_tick", 32'(bus.sec_tick), 0);
      cyc(1, 0, 0);
      chk("resume_tick", 32'(bus.sec_tick), 1);
      chk("resume_sec", 32'(bus.seconds), 31);
      // SET_MIN: wrap minutes around without carrying
      cyc(0, 1, 0);
      while (t / 60 != 0) cyc(0, 0, 1);
      repeat (61) cyc(1, 0, 1);
      chk("setmin_min", 32'(bus.minutes), 1);
      cyc(0, 1, 1);
      chk("mode_wins_state", 32'(bus.set_state), 2);
      chk("mode_wins_min", 32'(bus.minutes), 1);
      // SET_SEC: 59 wraps to 0 without touching minutes, blink cadence
      while (t % 60 != 59) cyc(0, 0, 1);
      cyc(0, 0, 1);
      chk("setsec_wrap", 32'(bus.seconds), 0);
      chk("setsec_min", 32'(bus.minutes), 1);
      repeat (6) cyc(0, 0, 0);
      cyc(1, 1, 0);
      repeat (4) cyc(1, 0, 0);
      chk("exit_tick", 32'(bus.sec_tick), 1);
      // inc_btn ignored in RUN
      cyc(1, 0, 1);
      // asynchronous reset mid-prescale in SET_SEC at 45:17
      set_time(45, 17, 1);
      cyc(0, 0, 0);
      #3;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("async_rst_state", 32'(bus.set_state), 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) cyc(0, 0, 0);
      // randomized traffic
      for (int k = 0; k < 1500; k++)
         cyc($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/hour_tick_timebase.md
Name: hour_tick_timebase

Overview:
Upstream timebase for the 24-hour counter. It divides the system clock to a 1 Hz tick, keeps seconds and minutes (00:00–59:59), and emits a one-cycle hour_tick pulse that drives the hour counter's count-enable. A small set-mode FSM lets the user adjust minutes and seconds with two pre-synchronised button pulses.

Parameters:
DIV, 50000000, clk cycles per second tick; legal range ≥2.
FAST_DIV, 4, divisor used instead of DIV when TIMEBASE_FAST_EN is defined; legal range ≥2.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
en  in  1  run enable; 0 freezes the prescaler and counters in RUN.
mode_btn  in  1  single-cycle pulse, already synchronised; advances the FSM.
inc_btn  in  1  single-cycle pulse, already synchronised; increments the selected field.
seconds  out  6  current seconds, 0–59.
minutes  out  6  current minutes, 0–59.
sec_tick  out  1  one-cycle pulse on each seconds advance in RUN.
hour_tick  out  1  one-cycle pulse on the 59:59→00:00 rollover; feeds the hour counter's en.
set_state  out  2  00=RUN, 01=SET_MIN, 10=SET_SEC; 11 never driven.
blink  out  1  display blink gate for the field being set.

Behaviour:
- Reset (reset_n low, asynchronous): state=RUN, prescaler=0, seconds=0, minutes=0, sec_tick=0, hour_tick=0, blink=0. All outputs are registered.
- Prescaler: width $clog2(D), where D = DIV (or FAST_DIV). It counts 0..D-1 and wraps to 0.
  - In RUN it advances only when en=1.
  - In SET_MIN and SET_SEC it advances every cycle regardless of en.
- RUN, en=1, prescaler==D-1 (terminal): on the same edge:
  - prescaler←0 and sec_tick←1 for exactly one cycle.
  - seconds←seconds+1; if seconds was 59, seconds←0 and minutes←minutes+1.
  - If minutes was 59 and seconds was 59: minutes←0, seconds←0, hour_tick←1 for exactly one cycle.
  - hour_tick is high in the first cycle the outputs read 00:00.
- Latency: terminal count → seconds/sec_tick/hour_tick updated at the next edge (1 cycle, registered).
- RUN, en=0: everything holds. Pulses deassert the cycle after they were asserted.
- FSM transitions, each on a mode_btn pulse:
  - RUN→SET_MIN: prescaler←0.
  - SET_MIN→SET_SEC.
  - SET_SEC→RUN: prescaler←0, so the first tick after exit comes D cycles later.
- SET_MIN: inc_btn → minutes←(minutes+1) mod 60. Never carries; seconds unchanged.
- SET_SEC: inc_btn → seconds←(seconds+1) mod 60. Never carries into minutes.
- sec_tick and hour_tick are never asserted outside RUN. A terminal count in a set state does not advance time.
- Simultaneous mode_btn and inc_btn: mode_btn wins, inc_btn is ignored that cycle.
- inc_btn in RUN is ignored.
- blink: 0 in RUN. In the set states, 1 while prescaler < D/2 (integer division), else 0.
- set_state mirrors the FSM register.
- Reset asserted mid-operation (any state, mid-prescale): immediate return to the reset values. No pulse is emitted on deassertion.

Optional Feature:
Macro TIMEBASE_FAST_EN.
- Defined: prescaler divisor is FAST_DIV, for simulation and demo of the world clock.
- Not defined: divisor is DIV. FAST_DIV is unused.
- All other behaviour is identical in both builds.

Test Plan:
- Reset with TIMEBASE_FAST_EN, FAST_DIV=4, en=1 for 12 cycles → seconds=3, minutes=0, sec_tick high on cycles 4, 8, 12 only, hour_tick=0.
- Preload via set mode to 59:58, return to RUN, run 8 cycles → 59:59 then 00:00. hour_tick high exactly one cycle, coincident with 00:00 and the sec_tick.
- RUN at 12:30, en=0 for 20 cycles → values unchanged, no pulses. Re-assert en → next tick after 4 − (held prescaler) cycles.
- mode_btn → set_state=01; 61 inc_btn pulses from minutes=0 → minutes=1, seconds unchanged, hour_tick never asserted. mode_btn+inc_btn in the same cycle → set_state=10, minutes still 1.
- SET_SEC at seconds=59, inc_btn → seconds=0, minutes unchanged. blink=1 for prescaler 0–1 and 0 for 2–3. mode_btn → RUN with prescaler=0.
- Drop reset_n for 1 cycle mid-prescale at 45:17 in SET_SEC → immediately 00:00, set_state=00, all pulses 0, blink=0.
